// File: rtl/sketch_ram_updater_if.sv
// rtl/sketch_ram_updater_if.sv - op request and result bus of the sketch counter updater
interface sketch_ram_updater_if #(
    parameter int DPW = 10,
    parameter int DW  = 64,
    parameter int IW  = 16
) ();
    logic           in_valid;
    logic           in_ready;
    logic [DPW-1:0] in_addr;
    logic [IW-1:0]  in_inc;
    logic           in_query;
    logic           out_valid;
    logic [DPW-1:0] out_addr;
    logic [DW-1:0]  out_data;

    modport master (
        output in_valid, in_addr, in_inc, in_query,
        input  in_ready, out_valid, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_inc, in_query,
        output in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/sketch_ram_updater.sv
// rtl/sketch_ram_updater.sv - RMW counter updater with forwarding and clear sweep; UPD_SATURATE_EN selects clamping
module sketch_ram_updater #(
    parameter int DPW = 10,
    parameter int DW  = 64,
    parameter int IW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    sketch_ram_updater_if.slave up,
    input  logic           clear_start,
    output logic           clear_done,
    output logic           ram_wea,
    output logic [DPW-1:0] ram_addra,
    output logic [DW-1:0]  ram_dina,
    input  logic [DW-1:0]  ram_douta,
    output logic           ram_web,
    output logic [DPW-1:0] ram_addrb,
    output logic [DW-1:0]  ram_dinb,
    input  logic [DW-1:0]  ram_doutb
);
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t         state;
    logic [DPW:0]   sweep;
    logic           s1_valid, s1_query;
    logic [IW-1:0]  s1_inc;
    logic           s2_valid, s2_query;
    logic [DPW-1:0] s2_addr;
    logic [IW-1:0]  s2_inc;
    logic           s3_query;
    logic           lw_valid;
    logic [DPW-1:0] lw_addr;
    logic [DW-1:0]  lw_data;
    logic [DW-1:0]  base, sum, result;
    logic [DW:0]    wide;
    logic           accept, pipe_empty;
    logic           unused_doutb;

    assign ram_wea      = 1'b0;
    assign ram_dina     = '0;
    assign unused_doutb = ^ram_doutb;
    assign accept       = up.in_valid && up.in_ready;
    assign pipe_empty   = !s1_valid && !s2_valid && !up.out_valid;

    // The S3 write lands on the edge after the S2 read, and the last-written
    // register covers the write that landed on the same edge as that read.
    always_comb begin
        base = ram_douta;
        if (up.out_valid && !s3_query && up.out_addr == s2_addr)
            base = up.out_data;
        else if (lw_valid && lw_addr == s2_addr)
            base = lw_data;
        wide = {1'b0, base} + {{(DW + 1 - IW){1'b0}}, s2_inc};
`ifdef UPD_SATURATE_EN
        sum = wide[DW] ? {DW{1'b1}} : wide[DW-1:0];
`else
        sum = wide[DW-1:0];
`endif
        result = s2_query ? base : sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sweep        <= '0;
            up.in_ready  <= 1'b0;
            up.out_valid <= 1'b0;
            up.out_addr  <= '0;
            up.out_data  <= '0;
            clear_done   <= 1'b0;
            ram_addra    <= '0;
            ram_web      <= 1'b0;
            ram_addrb    <= '0;
            ram_dinb     <= '0;
            s1_valid     <= 1'b0;
            s1_query     <= 1'b0;
            s1_inc       <= '0;
            s2_valid     <= 1'b0;
            s2_query     <= 1'b0;
            s2_addr      <= '0;
            s2_inc       <= '0;
            s3_query     <= 1'b0;
            lw_valid     <= 1'b0;
            lw_addr      <= '0;
            lw_data      <= '0;
        end else begin
            clear_done <= 1'b0;
            s1_valid   <= accept;
            if (accept) begin
                ram_addra <= up.in_addr;
                s1_inc    <= up.in_inc;
                s1_query  <= up.in_query;
            end
            s2_valid     <= s1_valid;
            s2_addr      <= ram_addra;
            s2_inc       <= s1_inc;
            s2_query     <= s1_query;
            up.out_valid <= s2_valid;
            if (s2_valid) begin
                up.out_addr <= s2_addr;
                up.out_data <= result;
                s3_query    <= s2_query;
            end
            // Sweep writes never feed the bypass; it reads as empty after a clear.
            lw_valid  <= ram_web && state != CLEAR;
            lw_addr   <= ram_addrb;
            lw_data   <= ram_dinb;
            ram_web   <= s2_valid && !s2_query;
            ram_addrb <= s2_addr;
            ram_dinb  <= sum;
            case (state)
                IDLE: begin
                    up.in_ready <= 1'b1;
                    if (clear_start) begin
                        state       <= DRAIN;
                        up.in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= CLEAR;
                        sweep <= '0;
                    end
                end
                CLEAR: begin
                    if (sweep[DPW]) begin
                        state       <= IDLE;
                        up.in_ready <= 1'b1;
                        clear_done  <= 1'b1;
                    end else begin
                        ram_web   <= 1'b1;
                        ram_addrb <= sweep[DPW-1:0];
                        ram_dinb  <= '0;
                        sweep     <= sweep + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sketch_ram_updater.sv
// tb/tb_sketch_ram_updater.sv - scoreboard bench for sketch_ram_updater with a behavioural RAM
module tb_sketch_ram_updater;
    localparam int DPW = 10;
    localparam int DW  = 64;
    localparam int IW  = 16;
`ifdef UPD_SATURATE_EN
    localparam logic [DW-1:0] SAT_EXP = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam logic [DW-1:0] SAT_EXP = 64'd3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sketch_ram_updater_if #(.DPW(DPW), .DW(DW), .IW(IW)) bus ();
    logic           clear_start, clear_done, ram_wea, ram_web;
    logic [DPW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0]  ram_dina, ram_douta, ram_dinb, ram_doutb;

    sketch_ram_updater #(.DPW(DPW), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .up(bus),
        .clear_start(clear_start), .clear_done(clear_done),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta),
        .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
    );

    logic [DW-1:0]  mem [0:(1<<DPW)-1];
    logic           bd_we;
    logic [DPW-1:0] bd_addr;
    logic [DW-1:0]  bd_data;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_web) mem[ram_addrb] <= ram_dinb;
        ram_douta <= mem[ram_addra];
        ram_doutb <= mem[ram_addrb];
    end

    typedef struct {
        logic [DPW-1:0] a;
        logic [DW-1:0]  d;
        int             c;
        logic           q;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out addr=%0d data=%0h cyc=%0d", bus.out_addr, bus.out_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_addr !== mon_e.a || bus.out_data !== mon_e.d || cyc != mon_e.c ||
                    (mon_e.q && ram_web !== 1'b0) ||
                    (!mon_e.q && (ram_web !== 1'b1 || ram_addrb !== mon_e.a || ram_dinb !== mon_e.d))) begin
                    n_bad++;
                    $display("FAIL result got addr=%0d data=%0h cyc=%0d web=%0b wdata=%0h, exp addr=%0d data=%0h cyc=%0d query=%0b",
                             bus.out_addr, bus.out_data, cyc, ram_web, ram_dinb, mon_e.a, mon_e.d, mon_e.c, mon_e.q);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [DPW-1:0] a, input logic [IW-1:0] inc, input logic q, input logic [DW-1:0] e);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_inc   = inc;
        bus.in_query = q;
        check("in_ready_at_issue", {63'd0, bus.in_ready}, 64'd1);
        sb.push_back('{a, e, cyc + 3, q});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bd_write(input logic [DPW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    int  zcnt, nxt, pulses;
    logic order_ok, rdy_ok, done_seen, found, web_seen;

    initial begin
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_inc = '0; bus.in_query = 1'b0;
        clear_start = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_ram_web", {63'd0, ram_web}, 64'd0);
        bd_write(3, 0); bd_write(5, 0); bd_write(7, 0); bd_write(9, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("post_rst_out_data", bus.out_data, 64'd0);
        check("post_rst_ram_addra", {54'd0, ram_addra}, 64'd0);
        check("ram_wea_dina", {63'd0, ram_wea} | ram_dina, 64'd0);

        issue(5, 1, 0, 1); issue(5, 1, 0, 2); issue(5, 1, 0, 3);
        idle(6);
        check("mem5_after_incs", mem[5], 64'd3);

        issue(7, 2, 0, 2); issue(7, 2, 0, 4); issue(9, 2, 0, 2); issue(7, 2, 0, 6);
        idle(6);
        check("mem7", mem[7], 64'd6);

        issue(5, 0, 1, 3);
        idle(4);
        issue(5, 1, 0, 4); issue(5, 0, 1, 4); issue(5, 1, 0, 5);
        idle(6);
        check("mem5_after_interleave", mem[5], 64'd5);

        bd_write(3, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(3, 5, 0, SAT_EXP);
        idle(6);

        issue(7, 1, 0, 7);
        clear_start = 1'b1;
        issue(9, 1, 0, 3);
        clear_start = 1'b0;
        bus.in_valid = 1'b0;
        check("in_ready_falls", {63'd0, bus.in_ready}, 64'd0);
        zcnt = 0; nxt = 0; order_ok = 1'b1; rdy_ok = 1'b1; done_seen = 1'b0;
        for (int i = 0; i < 2000 && !done_seen; i++) begin
            @(negedge clk);
            if (clear_done) begin
                done_seen = 1'b1;
                check("web_at_done", {63'd0, ram_web}, 64'd0);
            end else begin
                if (bus.in_ready) rdy_ok = 1'b0;
                if (ram_web && ram_dinb == 0) begin
                    if (ram_addrb != nxt[DPW-1:0]) order_ok = 1'b0;
                    nxt++;
                    zcnt++;
                end
            end
        end
        check("clear_done_seen", {63'd0, done_seen}, 64'd1);
        check("zero_write_count", 64'(zcnt), 64'd1024);
        check("sweep_order", {63'd0, order_ok}, 64'd1);
        check("in_ready_low_in_clear", {63'd0, rdy_ok}, 64'd1);
        @(posedge clk); #1;
        check("clear_done_pulse_width", {63'd0, clear_done}, 64'd0);
        check("in_ready_after_clear", {63'd0, bus.in_ready}, 64'd1);
        issue(5, 0, 1, 0); issue(7, 0, 1, 0); issue(9, 0, 1, 0); issue(3, 0, 1, 0);
        idle(6);

        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (ram_web && ram_addrb == 100 && ram_dinb == 0) found = 1'b1;
        end
        check("reached_addr_100", {63'd0, found}, 64'd1);
        rst = 1'b1;
        #1;
        check("midclr_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("midclr_web_valid_done", {61'd0, ram_web, bus.out_valid, clear_done}, 64'd0);
        check("midclr_addrs", {44'd0, ram_addrb, ram_addra}, 64'd0);
        check("midclr_dinb", ram_dinb, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_release", {63'd0, bus.in_ready}, 64'd1);
        pulses = 0; web_seen = 1'b0;
        repeat (1100) begin
            @(negedge clk);
            if (clear_done) pulses++;
            if (ram_web) web_seen = 1'b1;
        end
        check("no_clear_done_after_rst", 64'(pulses), 64'd0);
        check("no_sweep_after_rst", {63'd0, web_seen}, 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
